// File: rtl/sync_fifo_wr_arb.sv
// rtl/sync_fifo_wr_arb.sv - round-robin arbiter sharing one FIFO write port
module sync_fifo_wr_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_DEPTH = 16,
   parameter int N_REQ      = 4,
   parameter bit LOCK_EN    = 1'b1,
   localparam int CW        = $clog2(DATA_DEPTH) + 1,
   localparam int IW        = $clog2(N_REQ)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [N_REQ-1:0]            req_valid_i,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
   input  logic [N_REQ-1:0]            req_last_i,
   output logic [N_REQ-1:0]            req_ready_o,
   output logic                        fifo_wr_en_o,
   output logic [DATA_WIDTH-1:0]       fifo_data_in_o,
   input  logic [CW-1:0]               fifo_cnt_i,
   output logic [IW-1:0]               gnt_id_o,
   output logic                        busy_o
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_LOCK = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]         gnt_id_q, gnt_id_d;
   logic                  wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic [CW:0]           occ_sum;
   logic                  space_ok;
   logic                  found;
   logic [IW-1:0]         win;
   logic [IW-1:0]         hs_id;
   logic                  hs;

   // The registered write still in flight is counted as already occupying a slot.
   assign occ_sum  = {1'b0, fifo_cnt_i} + (CW+1)'(wr_en_q);
   assign space_ok = occ_sum < (CW+1)'(DATA_DEPTH);

   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         int idx;
         idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      hs_id       = (state_q == S_LOCK) ? gnt_id_q : win;
      if (!rst_i) begin
         if (state_q == S_LOCK) begin
            req_ready_o[gnt_id_q] = req_valid_i[gnt_id_q] & space_ok;
         end else if (found && space_ok) begin
            req_ready_o[win] = 1'b1;
         end
      end
      hs = |(req_ready_o & req_valid_i);
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_id_d = gnt_id_q;
      data_d   = data_q;
      wr_en_d  = hs;
      if (hs) begin
         rr_ptr_d = hs_id;
         gnt_id_d = hs_id;
         data_d   = req_data_i[hs_id*DATA_WIDTH +: DATA_WIDTH];
         state_d  = (LOCK_EN && !req_last_i[hs_id]) ? S_LOCK : S_IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= IW'(N_REQ - 1);
         gnt_id_q <= '0;
         wr_en_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_id_q <= gnt_id_d;
         wr_en_q  <= wr_en_d;
         data_q   <= data_d;
      end
   end

   assign fifo_wr_en_o   = wr_en_q;
   assign fifo_data_in_o = data_q;
   assign gnt_id_o       = gnt_id_q;
   assign busy_o         = (state_q == S_LOCK);

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// tb/tb_sync_fifo_wr_arb.sv - directed bench for sync_fifo_wr_arb
module tb_sync_fifo_wr_arb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  valid = '0, last = '0, ready;
   logic [31:0] data = '0;
   logic [4:0]  cnt = '0;
   logic        wr_en, busy;
   logic [7:0]  dout;
   logic [1:0]  gnt;

   logic [3:0]  valid2 = '0, last2 = '0, ready2;
   logic [31:0] data2 = '0;
   logic [4:0]  cnt2 = '0;
   logic        wr_en2, busy2;
   logic [7:0]  dout2;
   logic [1:0]  gnt2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sync_fifo_wr_arb #(.DATA_WIDTH(8), .DATA_DEPTH(16), .N_REQ(4), .LOCK_EN(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
      .req_ready_o(ready), .fifo_wr_en_o(wr_en), .fifo_data_in_o(dout), .fifo_cnt_i(cnt),
      .gnt_id_o(gnt), .busy_o(busy));

   sync_fifo_wr_arb #(.DATA_WIDTH(8), .DATA_DEPTH(16), .N_REQ(4), .LOCK_EN(1'b0)) dut_nolock (
      .clk_i(clk), .rst_i(rst), .req_valid_i(valid2), .req_data_i(data2), .req_last_i(last2),
      .req_ready_o(ready2), .fifo_wr_en_o(wr_en2), .fifo_data_in_o(dout2), .fifo_cnt_i(cnt2),
      .gnt_id_o(gnt2), .busy_o(busy2));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; valid = 4'hF; last = 4'hF; data = 32'hA3A2A1A0;
      step; step;
      #1;
      n_checks++; if (ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got %h exp 0", ready); end
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
      n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", dout); end
      n_checks++; if (gnt !== 2'd0) begin n_fail++; $display("FAIL reset_gnt got %0d exp 0", gnt); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      step;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++; if (ready !== 4'(1 << exp_id[k])) begin n_fail++; $display("FAIL rr_ready[%0d] got %h exp %h", k, ready, 4'(1 << exp_id[k])); end
         step;
         n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL rr_wr_en[%0d] got %b exp 1", k, wr_en); end
         n_checks++; if (dout !== 8'hA0 + 8'(exp_id[k])) begin n_fail++; $display("FAIL rr_data[%0d] got %h exp %h", k, dout, 8'hA0 + 8'(exp_id[k])); end
         n_checks++; if (gnt !== exp_id[k]) begin n_fail++; $display("FAIL rr_gnt[%0d] got %0d exp %0d", k, gnt, exp_id[k]); end
      end
      valid = 4'h0;
      step;
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rr_idle_wr_en got %b exp 0", wr_en); end
      n_checks++; if (dout !== 8'hA0) begin n_fail++; $display("FAIL rr_idle_hold got %h exp a0", dout); end
   endtask

   task automatic test_lock_packet;
      logic [7:0] beats [3] = '{8'h1A, 8'h1B, 8'h1C};
      valid = 4'b0110; last = 4'b0100; data = 32'h00_2A_00_00;
      for (int b = 0; b < 3; b++) begin
         data[15:8] = beats[b];
         last[1]    = (b == 2);
         #1;
         n_checks++; if (ready !== 4'b0010) begin n_fail++; $display("FAIL lock_ready[%0d] got %h exp 2", b, ready); end
         step;
         n_checks++; if (dout !== beats[b]) begin n_fail++; $display("FAIL lock_data[%0d] got %h exp %h", b, dout, beats[b]); end
         n_checks++; if (busy !== (b != 2)) begin n_fail++; $display("FAIL lock_busy[%0d] got %b exp %b", b, busy, b != 2); end
      end
      valid = 4'b0100;
      #1;
      n_checks++; if (ready !== 4'b0100) begin n_fail++; $display("FAIL lock_next_ready got %h exp 4", ready); end
      step;
      n_checks++; if (dout !== 8'h2A || gnt !== 2'd2 || wr_en !== 1'b1) begin n_fail++; $display("FAIL lock_next_beat got %h/%0d/%b exp 2a/2/1", dout, gnt, wr_en); end
      valid = 4'h0; last = 4'h0;
      step;
   endtask

   task automatic test_full_boundary;
      cnt = 5'd15; valid = 4'b0001; last = 4'b0001; data = 32'h000000F0;
      #1;
      n_checks++; if (ready !== 4'b0001) begin n_fail++; $display("FAIL full15_ready got %h exp 1", ready); end
      step;
      n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL full15_wr_en got %b exp 1", wr_en); end
      #1;
      n_checks++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL full15_inflight_ready got %h exp 0", ready); end
      step;
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL full15_no_wr got %b exp 0", wr_en); end
      cnt = 5'd16;
      #1;
      n_checks++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL full16_ready got %h exp 0", ready); end
      step;
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL full16_wr_en got %b exp 0", wr_en); end
      cnt = 5'd14;
      #1;
      n_checks++; if (ready !== 4'b0001) begin n_fail++; $display("FAIL full14_ready got %h exp 1", ready); end
      step;
      n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL full14_wr_en got %b exp 1", wr_en); end
      valid = 4'h0; cnt = 5'd0;
      step;
   endtask

   task automatic test_bubble;
      valid = 4'b1000; last = 4'b0000; data = 32'h31_00_00_00;
      #1;
      n_checks++; if (ready !== 4'b1000) begin n_fail++; $display("FAIL bubble_first_ready got %h exp 8", ready); end
      step;
      n_checks++; if (busy !== 1'b1 || gnt !== 2'd3) begin n_fail++; $display("FAIL bubble_lock got %b/%0d exp 1/3", busy, gnt); end
      valid = 4'b0111;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_checks++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL bubble_ready[%0d] got %h exp 0", c, ready); end
         step;
         n_checks++; if (wr_en !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bubble_hold[%0d] got %b/%b exp 0/1", c, wr_en, busy); end
      end
      valid = 4'b1111; data[31:24] = 8'h32;
      #1;
      n_checks++; if (ready !== 4'b1000) begin n_fail++; $display("FAIL bubble_resume_ready got %h exp 8", ready); end
      step;
      n_checks++; if (wr_en !== 1'b1 || dout !== 8'h32) begin n_fail++; $display("FAIL bubble_resume got %b/%h exp 1/32", wr_en, dout); end
      last = 4'b1000; data[31:24] = 8'h33;
      step;
      n_checks++; if (busy !== 1'b0 || dout !== 8'h33) begin n_fail++; $display("FAIL bubble_end got %b/%h exp 0/33", busy, dout); end
      valid = 4'h0; last = 4'h0;
      step;
   endtask

   task automatic test_reset_mid_packet;
      valid = 4'b0010; last = 4'b0000; data = 32'h4C_4B_4A_40;
      #1;
      n_checks++; if (ready !== 4'b0010) begin n_fail++; $display("FAIL rstmid_ready got %h exp 2", ready); end
      step;
      n_checks++; if (busy !== 1'b1 || wr_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b/%b exp 1/1", busy, wr_en); end
      rst = 1'b1;
      #1;
      n_checks++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ready_in_rst got %h exp 0", ready); end
      step;
      n_checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || gnt !== 2'd0) begin n_fail++; $display("FAIL rstmid_post got %b/%b/%0d exp 0/0/0", wr_en, busy, gnt); end
      rst = 1'b0; valid = 4'b1100; last = 4'b1100;
      #1;
      n_checks++; if (ready !== 4'b0100) begin n_fail++; $display("FAIL rstmid_first_ready got %h exp 4", ready); end
      step;
      n_checks++; if (gnt !== 2'd2 || dout !== 8'h4B) begin n_fail++; $display("FAIL rstmid_first_gnt got %0d/%h exp 2/4b", gnt, dout); end
      valid = 4'h0; last = 4'h0;
      step;
   endtask

   task automatic test_no_lock;
      logic [1:0] exp_id [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
      valid2 = 4'b0011; last2 = 4'b0000; data2 = 32'h0000_5150;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++; if (ready2 !== 4'(1 << exp_id[k])) begin n_fail++; $display("FAIL nolock_ready[%0d] got %h exp %h", k, ready2, 4'(1 << exp_id[k])); end
         step;
         n_checks++; if (gnt2 !== exp_id[k] || busy2 !== 1'b0) begin n_fail++; $display("FAIL nolock_gnt[%0d] got %0d/%b exp %0d/0", k, gnt2, busy2, exp_id[k]); end
         n_checks++; if (dout2 !== 8'h50 + 8'(exp_id[k])) begin n_fail++; $display("FAIL nolock_data[%0d] got %h exp %h", k, dout2, 8'h50 + 8'(exp_id[k])); end
      end
      valid2 = 4'h0;
      step;
   endtask

   initial begin
      test_reset;
      test_round_robin;
      test_lock_packet;
      test_full_boundary;
      test_bubble;
      test_reset_mid_packet;
      test_no_lock;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
